lsu_subword_rmw: RTL and testbench
==================================

Name: lsu_subword_rmw

Overview:
- Load/store unit between the core execute stage and the word-only data memory.
- Handles byte, halfword and word accesses. Sub-word stores are done as read-modify-write, because the memory only writes whole words.
- Loads return the extracted lane, sign-extended or zero-extended.
- Uses a valid/ready request handshake and a one-cycle response pulse. Misaligned accesses and illegal funct3 codes are flagged as errors.

Parameters:
- ADDR_W, 32, byte-address width on both the core side and the memory side.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; the operand is in the low bits.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  valid only with resp_valid; 1 = misaligned access or illegal funct3.
- mem_addr  out  ADDR_W  memory address: {latched_addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  merged word to write.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  combinational read data for mem_addr.

Behaviour:
- States: IDLE, ACCESS, WRITE, RESP, ERR. All are held in a registered state vector.
- Reset (rst_n=0 at an edge):
  - State becomes IDLE.
  - Registered outputs clear: resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0.
  - Captured word register clears to 0.
- mem_we is defined as (state==WRITE) & rst_n. No memory write occurs at an edge where reset is sampled.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we, funct3, addr and wdata.
  - If the request is illegal, go to ERR; otherwise go to ACCESS. No memory access happens in either case.
- Illegal requests:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: load with 011/110/111; store with funct3[2]=1 or 011.
- ACCESS:
  - mem_addr holds the aligned latched address.
  - Capture mem_rdata into the word register at the end of the cycle.
  - Load → RESP. Store → WRITE.
- WRITE (one cycle):
  - mem_we=1.
  - mem_wdata = captured word with the selected lanes replaced:
    - SB: lane addr[1:0] ← wdata[7:0].
    - SH: lanes {addr[1],0} and {addr[1],1} ← wdata[15:0].
    - SW: full wdata.
  - Then → RESP.
- RESP:
  - resp_valid=1 and resp_err=0 for one cycle, then → IDLE.
  - Loads: byte lane = word >> 8*addr[1:0]; halfword lane = word >> 16*addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW returns the whole word.
  - Stores: resp_rdata=0.
- ERR: resp_valid=1, resp_err=1, resp_rdata=0 for one cycle, then → IDLE. mem_we is never asserted.
- Latency, with acceptance at edge T:
  - Load: resp_valid is high in the cycle after edge T+1 (two cycles after acceptance).
  - Store: resp_valid after T+2.
  - Error: resp_valid after T.
- Throughput:
  - req_ready=0 in every non-IDLE state, and req inputs are ignored there.
  - The next request can be accepted in the cycle right after the RESP/ERR cycle.
- req_wdata, req_addr and req_funct3 may change after acceptance without effect.
- Reset mid-operation: the in-flight access is abandoned, no response is issued, and memory is unchanged if reset lands in WRITE.
- resp_valid never lasts more than one cycle. The core has no backpressure on responses.

Test Plan:
- Memory word 0x10 = 0x8844_22F1. LB addr 0x10 → resp_rdata 0xFFFF_FFF1. LBU addr 0x11 → 0x0000_0022. LH addr 0x12 → 0xFFFF_8844. LHU addr 0x12 → 0x0000_8844. Each load gives resp_valid 2 cycles after acceptance.
- Word 0x20 = 0xAABB_CCDD. SB addr 0x22 wdata 0x1234_5677 → exactly one mem_we pulse with mem_addr 0x20 and mem_wdata 0xAA77_CCDD; resp_valid 3 cycles after acceptance; LW 0x20 then returns 0xAA77_CCDD.
- SH addr 0x20 wdata 0x0000_BEEF on word 0xAABB_CCDD → written word 0xAABB_BEEF. SW addr 0x24 wdata 0xCAFE_F00D → 0xCAFE_F00D.
- SH addr 0x21, LW addr 0x26, and load funct3 011 → each gives resp_valid with resp_err=1 the cycle after acceptance, mem_we stays 0, and memory is unchanged.
- Back-to-back: req_valid held high with SB, LW, LB queued → req_ready low while busy; requests are accepted one cycle after each response; responses come in order with correct data.
- Reset: SB to 0x30 (word 0x1111_1111), rst_n=0 while state is WRITE → mem_we=0 at that edge, no resp_valid, word stays 0x1111_1111; after release, all outputs are 0 and req_ready=1.

Source files
------------

// File: rtl/lsu_subword_rmw.sv
// Load/store unit between execute and a word-only data memory.
// Sub-word stores are performed as a read-modify-write of the containing word.
module lsu_subword_rmw #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  // state  | meaning
  // IDLE   | ready for a request
  // ACCESS | read the aligned word, capture it
  // WRITE  | write the merged word (stores only)
  // RESP   | one-cycle good response
  // ERR    | one-cycle error response
  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_RESP,
    S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_word;

  logic              w_bad_f3;
  logic              w_misalign;
  logic [4:0]        w_shift_b;
  logic [4:0]        w_shift_h;
  logic [31:0]       w_word_b;
  logic [31:0]       w_word_h;
  logic [31:0]       w_load;
  logic [31:0]       w_mask;
  logic [31:0]       w_ins;
  logic [31:0]       w_merged;

  always_comb begin
    w_bad_f3   = 1'b0;
    w_misalign = 1'b0;
    if (req_we) begin
      w_bad_f3 = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    end else begin
      w_bad_f3 = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
    end
    case (req_funct3[1:0])
      2'b01:   w_misalign = req_addr[0];
      2'b10:   w_misalign = |req_addr[1:0];
      default: w_misalign = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = (w_bad_f3 | w_misalign) ? S_ERR : S_ACCESS;
        end
      end
      S_ACCESS: w_state_nxt = r_we ? S_WRITE : S_RESP;
      S_WRITE:  w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      S_ERR:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_word   <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && req_valid) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (r_state == S_ACCESS) begin
        r_word <= mem_rdata;
      end
    end
  end

  assign w_shift_b = {r_addr[1:0], 3'b000};
  assign w_shift_h = {r_addr[1], 4'b0000};
  assign w_word_b  = r_word >> w_shift_b;
  assign w_word_h  = r_word >> w_shift_h;

  always_comb begin
    w_load = 32'h0;
    case (r_funct3)
      3'b000:  w_load = {{24{w_word_b[7]}}, w_word_b[7:0]};
      3'b001:  w_load = {{16{w_word_h[15]}}, w_word_h[15:0]};
      3'b010:  w_load = r_word;
      3'b100:  w_load = {24'h0, w_word_b[7:0]};
      3'b101:  w_load = {16'h0, w_word_h[15:0]};
      default: w_load = 32'h0;
    endcase
  end

  // Lanes outside the mask keep the word captured during ACCESS.
  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    w_ins  = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_mask = 32'h0000_00FF << w_shift_b;
        w_ins  = {24'h0, r_wdata[7:0]} << w_shift_b;
      end
      2'b01: begin
        w_mask = 32'h0000_FFFF << w_shift_h;
        w_ins  = {16'h0, r_wdata[15:0]} << w_shift_h;
      end
      default: begin
        w_mask = 32'hFFFF_FFFF;
        w_ins  = r_wdata;
      end
    endcase
  end

  assign w_merged = (r_word & ~w_mask) | (w_ins & w_mask);

  assign resp_valid = (r_state == S_RESP) | (r_state == S_ERR);
  assign resp_err   = (r_state == S_ERR);
  assign resp_rdata = (r_state == S_RESP && !r_we) ? w_load : 32'h0;
  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = (r_state == S_WRITE) ? w_merged : 32'h0;
  assign mem_we     = (r_state == S_WRITE) & rst_n;

endmodule

// File: tb/tb_lsu_subword_rmw.sv
// Directed bench for lsu_subword_rmw with a word-addressed memory model.
module tb_lsu_subword_rmw;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;

  int          checks;
  int          errors;
  int          cyc;
  int          we_cnt;
  logic [31:0] last_we_addr;
  logic [31:0] last_we_data;
  int          ready_bad;
  int          pulse_bad;

  lsu_subword_rmw #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    else if (bd_we) mem[bd_idx] <= bd_data;
  end

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt       = we_cnt + 1;
      last_we_addr = mem_addr;
      last_we_data = mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] data);
    bd_idx  = idx;
    bd_data = data;
    bd_we   = 1'b1;
    @(posedge clk); #1;
    bd_we   = 1'b0;
  endtask

  // Issues one request and returns the latency (1 = cycle after acceptance).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat,
                        output logic [31:0] rdata, output logic err);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'hFFFF_FFFF;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      if (req_ready) ready_bad++;
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clk); #1;
    if (resp_valid || !req_ready) pulse_bad++;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          w0;
    logic [2:0]  q_f3   [0:2];
    logic        q_we   [0:2];
    logic [31:0] q_addr [0:2];
    logic [31:0] q_wd   [0:2];
    int          acc_cyc  [0:2];
    int          resp_cyc [0:2];
    logic [31:0] resp_dat [0:2];
    int          idx;
    int          nresp;
    logic        rdy;
    int          bad_resp;

    checks = 0; errors = 0; cyc = 0; we_cnt = 0;
    last_we_addr = 32'h0; last_we_data = 32'h0;
    ready_bad = 0; pulse_bad = 0;
    bd_we = 1'b0; bd_idx = 6'd0; bd_data = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;

    @(posedge clk); #1;
    poke(6'h04, 32'h8844_22F1);
    poke(6'h08, 32'hAABB_CCDD);
    poke(6'h09, 32'h0000_0000);
    poke(6'h0C, 32'h1111_1111);
    poke(6'h10, 32'h0102_0304);
    rst_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

    do_req(1'b0, 3'b000, 32'h10, 32'h0, lat, rd, er);
    chk("lb_data", rd, 32'hFFFF_FFF1);
    chk("lb_lat", lat, 2);
    chk("lb_err", {31'h0, er}, 32'h0);
    do_req(1'b0, 3'b100, 32'h11, 32'h0, lat, rd, er);
    chk("lbu_data", rd, 32'h0000_0022);
    chk("lbu_lat", lat, 2);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, lat, rd, er);
    chk("lh_data", rd, 32'hFFFF_8844);
    chk("lh_lat", lat, 2);
    do_req(1'b0, 3'b101, 32'h12, 32'h0, lat, rd, er);
    chk("lhu_data", rd, 32'h0000_8844);

    w0 = we_cnt;
    do_req(1'b1, 3'b000, 32'h22, 32'h1234_5677, lat, rd, er);
    chk("sb_we_count", we_cnt - w0, 1);
    chk("sb_we_addr", last_we_addr, 32'h20);
    chk("sb_we_data", last_we_data, 32'hAA77_CCDD);
    chk("sb_lat", lat, 3);
    chk("sb_rdata", rd, 32'h0);
    chk("sb_err", {31'h0, er}, 32'h0);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er);
    chk("lw_after_sb", rd, 32'hAA77_CCDD);

    poke(6'h08, 32'hAABB_CCDD);
    do_req(1'b1, 3'b001, 32'h20, 32'h0000_BEEF, lat, rd, er);
    chk("sh_mem", mem[8], 32'hAABB_BEEF);
    chk("sh_lat", lat, 3);
    do_req(1'b1, 3'b010, 32'h24, 32'hCAFE_F00D, lat, rd, er);
    chk("sw_mem", mem[9], 32'hCAFE_F00D);
    do_req(1'b1, 3'b001, 32'h26, 32'hFFFF_1234, lat, rd, er);
    chk("sh_upper_mem", mem[9], 32'h1234_F00D);

    w0 = we_cnt;
    do_req(1'b1, 3'b001, 32'h21, 32'h0000_5555, lat, rd, er);
    chk("sh_mis_err", {31'h0, er}, 32'h1);
    chk("sh_mis_lat", lat, 1);
    chk("sh_mis_rdata", rd, 32'h0);
    do_req(1'b0, 3'b010, 32'h26, 32'h0, lat, rd, er);
    chk("lw_mis_err", {31'h0, er}, 32'h1);
    chk("lw_mis_lat", lat, 1);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, lat, rd, er);
    chk("ld_f3_err", {31'h0, er}, 32'h1);
    chk("ld_f3_rdata", rd, 32'h0);
    do_req(1'b1, 3'b100, 32'h24, 32'h0, lat, rd, er);
    chk("st_f3_err", {31'h0, er}, 32'h1);
    chk("err_no_write", we_cnt - w0, 0);
    chk("err_mem8", mem[8], 32'hAABB_BEEF);
    chk("err_mem9", mem[9], 32'h1234_F00D);

    // Back-to-back with req_valid held high.
    q_we[0] = 1'b1; q_f3[0] = 3'b000; q_addr[0] = 32'h41; q_wd[0] = 32'h0000_00A5;
    q_we[1] = 1'b0; q_f3[1] = 3'b010; q_addr[1] = 32'h40; q_wd[1] = 32'h0;
    q_we[2] = 1'b0; q_f3[2] = 3'b000; q_addr[2] = 32'h41; q_wd[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      acc_cyc[i] = -100; resp_cyc[i] = 0; resp_dat[i] = 32'h0;
    end
    idx = 0; nresp = 0; bad_resp = 0;
    req_valid = 1'b1; req_we = q_we[0]; req_funct3 = q_f3[0];
    req_addr = q_addr[0]; req_wdata = q_wd[0];
    for (int c = 0; c < 60 && nresp < 3; c++) begin
      rdy = req_ready;
      @(posedge clk); #1;
      if (rdy && req_valid) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) begin
          req_we = q_we[idx]; req_funct3 = q_f3[idx];
          req_addr = q_addr[idx]; req_wdata = q_wd[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (resp_valid) begin
        if (req_ready || resp_err) bad_resp++;
        resp_cyc[nresp] = cyc;
        resp_dat[nresp] = resp_rdata;
        nresp++;
      end
    end
    req_valid = 1'b0;
    chk("b2b_nresp", nresp, 3);
    chk("b2b_sb_rdata", resp_dat[0], 32'h0);
    chk("b2b_lw_rdata", resp_dat[1], 32'h0102_A504);
    chk("b2b_lb_rdata", resp_dat[2], 32'hFFFF_FFA5);
    chk("b2b_acc1", acc_cyc[1], resp_cyc[0] + 2);
    chk("b2b_acc2", acc_cyc[2], resp_cyc[1] + 2);
    chk("b2b_busy_ready", bad_resp, 0);
    @(posedge clk); #1;

    // Reset lands while the SB is in WRITE.
    w0 = we_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h30; req_wdata = 32'h0000_0022;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_in_write", {31'h0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #0;
    chk("rstmid_we_gated", {31'h0, mem_we}, 32'h0);
    bad_resp = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (resp_valid) bad_resp++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (resp_valid) bad_resp++;
    end
    chk("rstmid_no_resp", bad_resp, 0);
    chk("rstmid_no_write", we_cnt - w0, 0);
    chk("rstmid_mem", mem[12], 32'h1111_1111);
    chk("rstmid_mem_addr", mem_addr, 32'h0);
    chk("rstmid_mem_wdata", mem_wdata, 32'h0);
    chk("rstmid_rdata", resp_rdata, 32'h0);
    chk("rstmid_err", {31'h0, resp_err}, 32'h0);
    chk("rstmid_ready", {31'h0, req_ready}, 32'h1);

    chk("ready_low_busy", ready_bad, 0);
    chk("resp_one_cycle", pulse_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
